// File: rtl/imul_dot_accumulator.sv
// Dot-product accumulator: sums a group of products and emits the total on a val/rdy stream.
// Optional build macro IMUL_DOT_ACCUMULATOR_SATURATE_EN selects an unsigned saturating add.
module imul_dot_accumulator #(
  parameter int p_nbits   = 32,
  parameter int p_max_len = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits:0]   istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int c_cw = $clog2(p_max_len + 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [p_nbits-1:0] r_sum;
  logic [p_nbits-1:0] w_sum_next;
  logic [c_cw-1:0]    r_count;
  logic [c_cw-1:0]    w_count_next;
  logic [c_cw-1:0]    w_count_inc;
  logic               w_last;

  function automatic logic [p_nbits-1:0] f_add(input logic [p_nbits-1:0] a,
                                               input logic [p_nbits-1:0] b);
    logic [p_nbits:0] w_full;
    w_full = {1'b0, a} + {1'b0, b};
`ifdef IMUL_DOT_ACCUMULATOR_SATURATE_EN
    if (w_full[p_nbits]) begin
      f_add = {p_nbits{1'b1}};
    end else begin
      f_add = w_full[p_nbits-1:0];
    end
`else
    f_add = w_full[p_nbits-1:0];
`endif
  endfunction

  assign w_count_inc = r_count + {{(c_cw-1){1'b0}}, 1'b1};
  assign w_last      = istream_msg[p_nbits] || (w_count_inc == c_cw'(p_max_len));

  // Next-state logic: accumulate while in ACCUM, drain the sum while in DONE
  always_comb begin
    w_state_next = r_state;
    w_sum_next   = r_sum;
    w_count_next = r_count;
    case (r_state)
      ST_ACCUM: begin
        if (istream_val) begin
          w_sum_next   = f_add(r_sum, istream_msg[p_nbits-1:0]);
          w_count_next = w_count_inc;
          if (w_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_ACCUM;
          end
        end else begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (ostream_rdy) begin
          w_state_next = ST_ACCUM;
          w_sum_next   = {p_nbits{1'b0}};
          w_count_next = {c_cw{1'b0}};
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_ACCUM;
        w_sum_next   = {p_nbits{1'b0}};
        w_count_next = {c_cw{1'b0}};
      end
    endcase
  end

  // State register with synchronous active-low reset that discards any partial group
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ACCUM;
      r_sum   <= {p_nbits{1'b0}};
      r_count <= {c_cw{1'b0}};
    end else begin
      r_state <= w_state_next;
      r_sum   <= w_sum_next;
      r_count <= w_count_next;
    end
  end

  // Handshake outputs depend only on registered state, never on the opposite valid/ready
  assign istream_rdy = (r_state == ST_ACCUM);
  assign ostream_val = (r_state == ST_DONE);
  assign ostream_msg = r_sum;

`ifndef SYNTHESIS
  function automatic string line_trace();
    string s_st;
    if (r_state == ST_ACCUM) begin
      s_st = $sformatf("(A %0d)", r_count);
    end else begin
      s_st = "(D)";
    end
    return $sformatf("%b%b:%h %s %b%b:%h", istream_val, istream_rdy, istream_msg,
                     s_st, ostream_val, ostream_rdy, ostream_msg);
  endfunction
`endif

endmodule

// File: doc/imul_dot_accumulator.md
Name: imul_dot_accumulator

Overview:
- Downstream consumer of the fixed-latency integer multiplier's output stream.
- Accumulates a group of 32-bit products into one dot-product sum and emits the sum on a val/rdy output stream.
- A group ends on a tagged "last" product or when p_max_len products have been accepted, whichever comes first.
- Sits between the multiplier ostream and the result sink, so the multiplier plus this block form a dot-product unit.

Parameters:
- p_nbits, 32, width of products and of the sum.
- p_max_len, 8, maximum products per group; must be ≥1. The group closes automatically on the p_max_len-th product.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
- istream_val  input  1  product valid.
- istream_rdy  output  1  block can accept a product.
- istream_msg  input  p_nbits+1  [p_nbits] = last flag; [p_nbits-1:0] = product (unsigned).
- ostream_val  output  1  sum valid.
- ostream_rdy  input  1  sink accepts sum.
- ostream_msg  output  p_nbits  accumulated sum.

Behaviour:
- Transfer occurs on a posedge where val && rdy, on either stream.
- State registers:
  - state ∈ {ACCUM, DONE}.
  - sum[p_nbits-1:0].
  - count, $clog2(p_max_len+1) bits.
- Reset (reset==0 at posedge), from any state including mid-group:
  - state=ACCUM, sum=0, count=0.
  - Any partial group is discarded; nothing is emitted for it.
- Outputs are pure functions of registered state, with no combinational val→rdy paths:
  - istream_rdy = (state==ACCUM).
  - ostream_val = (state==DONE).
  - ostream_msg = sum.
- Values during reset and on the first cycle after release: istream_rdy=1, ostream_val=0, ostream_msg=0.
- ACCUM, on an input transfer:
  - sum <= sum + product, truncated to p_nbits (modular wrap).
  - count <= count+1.
  - If last flag==1 or count+1==p_max_len: state <= DONE.
- ACCUM with no transfer: hold all state.
- DONE:
  - istream_rdy=0; products are back-pressured.
  - When ostream_rdy==1: sum <= 0, count <= 0, state <= ACCUM.
  - Otherwise hold; ostream_msg stays stable while ostream_val is high.
- Latency: sum appears on ostream_msg with ostream_val=1 on the cycle after the closing product transfers.
- Throughput: a group of N products takes N input cycles plus ≥1 DONE cycle. Back-to-back groups therefore have a 1-cycle input bubble.
- Group of one (last=1 on the first product, or p_max_len==1): state goes to DONE immediately; sum = that product.
- Last flag on the p_max_len-th product: closes normally, as a single group end.
- Empty groups are impossible; a group is only created by an accepted product.
- istream_msg is ignored when istream_val==0 or istream_rdy==0.
- Simultaneous ostream_rdy in DONE and istream_val: the input is not accepted that cycle, because istream_rdy is derived from the DONE state. It is accepted on the next cycle in ACCUM.
- Line trace (non-synthesis) shows the input val/rdy/msg, "(A count)" or "(D)", and the output val/rdy/msg.

Optional Feature:
- Macro: IMUL_DOT_ACCUMULATOR_SATURATE_EN.
- Defined: the add is unsigned saturating. If sum + product exceeds 2^p_nbits-1, sum becomes 2^p_nbits-1 and stays there until the group ends.
- Not defined: modular wrap-around as above.
- All other timing and handshaking is identical in both builds.

Test Plan:
- Products 3,5,7 with last on 7, sink always ready → single output 0x0000000F one cycle after 7 accepted; istream_rdy low for exactly 1 cycle.
- p_max_len=8; eight products of 0x10, no last flag → output 0x00000080 after the 8th; ninth product is stalled until the sum transfers, then starts a new group.
- Single product 0x1234 with last=1, ostream_rdy held 0 for 5 cycles → ostream_val=1 with msg 0x00001234 stable for all 5 cycles; istream_rdy=0 throughout; transfer on the 6th cycle.
- 0xFFFFFFF0 then 0x20 with last → 0x00000010 without the macro; 0xFFFFFFFF with IMUL_DOT_ACCUMULATOR_SATURATE_EN.
- Two products (1,2) accepted, then reset=0 for 1 cycle, then 4 with last → output 0x00000004; no output for the partial group.
- Random val/rdy bubbles over 100 random groups (lengths 1..8), compared against a software reference sum → all sums match, in order.
